// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing for the round-robin fifo write arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Wide enough for BURST_LEN up to 255.
    localparam int BEAT_BITS = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus fifo write-port bundle; master is the arbiter side.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_BITS    = 2
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        fifo_full;
    logic                        fifo_wr_en;
    logic [ID_BITS+DATA_WIDTH-1:0] fifo_data_in;
    logic                        grant_valid;
    logic [ID_BITS-1:0]          grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module fifo_wr_arbiter_rr_pick #(
    parameter int N_REQ   = 4,
    parameter int ID_BITS = 2
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [ID_BITS-1:0] last,
    output logic               any,
    output logic [ID_BITS-1:0] idx
);
    logic [N_REQ-1:0] req_rot;
    int               cand;

    // Scan from the farthest candidate back so the nearest one after 'last' wins.
    always_comb begin
        any     = 1'b0;
        idx     = '0;
        req_rot = '0;
        cand    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand    = (int'(last) + k) % N_REQ;
            req_rot = req >> cand;
            if (req_rot[0]) begin
                any = 1'b1;
                idx = ID_BITS'(cand);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: one owner at a time writes up to BURST_LEN tagged words.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_BITS    = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.master  bus
);
    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BURST_LEN - 1);

    arb_state_e           state_q, state_d;
    logic [ID_BITS-1:0]   owner_q, owner_d;
    logic [ID_BITS-1:0]   last_q, last_d;
    logic [BEAT_BITS-1:0] beat_q, beat_d;

    logic                  pick_any;
    logic [ID_BITS-1:0]    pick_idx;
    logic [N_REQ-1:0]      owner_oh;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  own;
    logic                  owner_valid;
    logic                  xfer;

    fifo_wr_arbiter_rr_pick #(
        .N_REQ   (N_REQ),
        .ID_BITS (ID_BITS)
    ) u_rr_pick (
        .req  (bus.req_valid),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        owner_oh   = '0;
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == ID_BITS'(i)) begin
                owner_oh[i] = 1'b1;
                owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        own         = (state_q == ST_OWN);
        owner_valid = |(bus.req_valid & owner_oh);
        // A full fifo only stalls the owner; it never forces release.
        xfer        = own && owner_valid && !bus.fifo_full;
    end

    assign bus.req_ready    = (own && !bus.fifo_full) ? owner_oh : '0;
    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_data_in = own ? {owner_q, owner_data} : '0;
    assign bus.grant_valid  = own;
    assign bus.grant_id     = own ? owner_q : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_OWN;
                    owner_d = pick_idx;
                    beat_d  = '0;
                end
            end
            ST_OWN: begin
                if (!owner_valid || (xfer && beat_q == BEAT_LAST)) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (xfer) begin
                    beat_d = beat_q + BEAT_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= ID_BITS'(N_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end
endmodule
